// File: rtl/dvi_tx_core_if.sv
// Serial TMDS data lanes leaving the transmitter core, one bit per tmds_clk per lane.
// No backpressure: the sink samples every bit.
interface dvi_tx_core_if;
   logic signal_r;
   logic signal_g;
   logic signal_b;

   modport master (output signal_r, output signal_g, output signal_b);
   modport slave  (input  signal_r, input  signal_g, input  signal_b);
endinterface

// File: rtl/dvi_tx_core.sv
// 640x480 colour-bar DVI source: timing, three TMDS 8b/10b encoders, 10:1 serializers.
// A pixel's bit 0 reaches its lane two pixel periods after the pixel is current; no backpressure.
module dvi_tmds_enc (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       de,
   input  logic [7:0] d,
   input  logic [1:0] ctl,
   output logic [9:0] q
);
   logic [3:0] n1_d;
   logic [3:0] n1_qm;
   logic       use_xnor;
   logic       acc;
   logic [8:0] qm;
   logic [4:0] disp;
   logic [4:0] delta;
   logic       invert;
   logic [9:0] q_nxt;
   logic [4:0] cnt_nxt;
   logic [4:0] cnt   = '0;
   logic [9:0] q_reg = '0;

   always_comb begin
      n1_d     = '0;
      n1_qm    = '0;
      qm       = '0;
      acc      = d[0];
      for (int i = 0; i < 8; i++) n1_d = n1_d + {3'b000, d[i]};
      use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) begin
         acc   = acc ^ d[i] ^ use_xnor;
         qm[i] = acc;
      end
      qm[8] = !use_xnor;
      for (int i = 0; i < 8; i++) n1_qm = n1_qm + {3'b000, qm[i]};
      // disp = ones - zeros of qm[7:0]; cnt and disp are two's complement 5-bit
      disp   = {n1_qm, 1'b0} - 5'd8;
      invert = (!cnt[4] && (cnt != 5'd0) && !disp[4] && (disp != 5'd0)) ||
               (cnt[4] && disp[4]);
      if (invert) delta = (5'd0 - disp) + (qm[8] ? 5'd2 : 5'd0);
      else        delta = disp - (qm[8] ? 5'd0 : 5'd2);
      cnt_nxt = cnt + delta;
      q_nxt   = {invert, qm[8], invert ? ~qm[7:0] : qm[7:0]};
      if (!de) begin
         cnt_nxt = '0;
         case (ctl)
            2'b00:   q_nxt = 10'h354;
            2'b01:   q_nxt = 10'h0AB;
            2'b10:   q_nxt = 10'h154;
            default: q_nxt = 10'h2AB;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         q_reg <= '0;
      end else if (en) begin
         cnt   <= cnt_nxt;
         q_reg <= q_nxt;
      end
   end

   assign q = q_reg;
endmodule

module dvi_tx_core (
   input  logic          tmds_clk,
   input  logic          rst,
   input  logic          pix_clk,
   dvi_tx_core_if.master lanes
);
   localparam logic [9:0] H_ACTIVE     = 10'd640;
   localparam logic [9:0] H_TOTAL      = 10'd800;
   localparam logic [9:0] H_SYNC_START = 10'd656;
   localparam logic [9:0] H_SYNC_END   = 10'd752;
   localparam logic [9:0] V_ACTIVE     = 10'd480;
   localparam logic [9:0] V_TOTAL      = 10'd525;
   localparam logic [9:0] V_SYNC_START = 10'd490;
   localparam logic [9:0] V_SYNC_END   = 10'd492;

   logic [3:0]       bit_cnt = '0;
   logic [9:0]       hcnt    = '0;
   logic [9:0]       vcnt    = '0;
   logic [2:0][9:0]  shift   = '0;
   logic             pix_en;
   logic             de;
   logic             hsync_n;
   logic             vsync_n;
   logic [2:0]       bar;
   logic [2:0]       rgb;
   logic [9:0]       enc_r;
   logic [9:0]       enc_g;
   logic [9:0]       enc_b;
   logic [2:0][9:0]  enc;
   logic             unused_pix_clk;

   // Pixel rate is derived from bit_cnt; the external pixel clock is only a legacy pin.
   assign unused_pix_clk = pix_clk;

   assign pix_en  = (bit_cnt == 4'd9);
   assign de      = (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE);
   assign hsync_n = !((hcnt >= H_SYNC_START) && (hcnt < H_SYNC_END));
   assign vsync_n = !((vcnt >= V_SYNC_START) && (vcnt < V_SYNC_END));

   always_ff @(posedge tmds_clk) begin
      if (rst) begin
         bit_cnt <= '0;
         hcnt    <= '0;
         vcnt    <= '0;
      end else begin
         bit_cnt <= pix_en ? 4'd0 : bit_cnt + 4'd1;
         if (pix_en) begin
            if (hcnt == H_TOTAL - 10'd1) begin
               hcnt <= '0;
               vcnt <= (vcnt == V_TOTAL - 10'd1) ? 10'd0 : vcnt + 10'd1;
            end else begin
               hcnt <= hcnt + 10'd1;
            end
         end
      end
   end

   // Bar order white,yellow,cyan,green,magenta,red,blue,black maps onto inverted index bits.
   always_comb begin
      bar = '0;
      for (int i = 1; i < 8; i++) begin
         if (hcnt >= 10'(80 * i)) bar = 3'(i);
      end
      rgb = {~bar[1], ~bar[2], ~bar[0]};
   end

   dvi_tmds_enc u_enc_r (
      .clk (tmds_clk), .rst (rst), .en (pix_en), .de (de),
      .d   ({8{rgb[2]}}), .ctl (2'b00), .q (enc_r)
   );
   dvi_tmds_enc u_enc_g (
      .clk (tmds_clk), .rst (rst), .en (pix_en), .de (de),
      .d   ({8{rgb[1]}}), .ctl (2'b00), .q (enc_g)
   );
   dvi_tmds_enc u_enc_b (
      .clk (tmds_clk), .rst (rst), .en (pix_en), .de (de),
      .d   ({8{rgb[0]}}), .ctl ({vsync_n, hsync_n}), .q (enc_b)
   );

   assign enc = {enc_r, enc_g, enc_b};

   always_ff @(posedge tmds_clk) begin
      if (rst) begin
         shift <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (pix_en) shift[i] <= enc[i];
            else        shift[i] <= {1'b0, shift[i][9:1]};
         end
      end
   end

   assign lanes.signal_r = shift[2][0];
   assign lanes.signal_g = shift[1][0];
   assign lanes.signal_b = shift[0][0];
endmodule

// File: tb/tb_dvi_tx_core.sv
// Bench for dvi_tx_core: whole-symbol comparison of all three lanes against a pixel-level model.
module tb_dvi_tx_core;
   logic tmds_clk = 1'b0;
   logic rst      = 1'b1;
   logic pix_clk  = 1'b0;

   dvi_tx_core_if lanes ();

   dvi_tx_core dut (
      .tmds_clk (tmds_clk),
      .rst      (rst),
      .pix_clk  (pix_clk),
      .lanes    (lanes)
   );

   always #5  tmds_clk = ~tmds_clk;
   always #50 pix_clk  = ~pix_clk;

   typedef struct {
      logic [29:0] sym;
      int          h;
      int          v;
   } exp_t;

   exp_t pipe[$];
   int   mh, mv;
   int   mcnt[3];
   int   psince;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // DVI encoding chosen by disparity of whole candidate words.
   task automatic ref_enc(input logic [7:0] d, input bit de_m, input bit [1:0] c,
                          input int cnt_in, output logic [9:0] sym, output int cnt_out);
      logic [9:0] ctrl [4];
      logic [7:0] qm;
      bit         use_xnor;
      int         n, bal;
      ctrl = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
      if (!de_m) begin
         sym     = ctrl[c];
         cnt_out = 0;
         return;
      end
      n        = $countones(d);
      use_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
      qm[0]    = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      bal = $countones(qm) - 4;
      if ((cnt_in > 0 && bal > 0) || (cnt_in < 0 && bal < 0)) sym = {1'b1, !use_xnor, ~qm};
      else                                                    sym = {1'b0, !use_xnor, qm};
      cnt_out = cnt_in + 2 * $countones(sym) - 10;
   endtask

   task automatic model_pixel(output exp_t e);
      logic [2:0] bars [8];
      logic [2:0] rgb;
      logic [9:0] s;
      bit         de_m, hs_n, vs_n;
      int         c_out;
      bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
      rgb  = (mh < 640) ? bars[mh / 80] : 3'b000;
      de_m = (mh < 640) && (mv < 480);
      hs_n = !(mh >= 656 && mh < 752);
      vs_n = !(mv >= 490 && mv < 492);
      e.sym = '0;
      for (int l = 0; l < 3; l++) begin
         ref_enc(rgb[l] ? 8'hFF : 8'h00, de_m, (l == 0) ? {vs_n, hs_n} : 2'b00,
                 mcnt[l], s, c_out);
         mcnt[l] = c_out;
         e.sym[l*10 +: 10] = s;
      end
      e.h = mh;
      e.v = mv;
   endtask

   task automatic reset_model();
      exp_t z;
      z.sym = '0; z.h = -1; z.v = -1;
      mh = 0; mv = 0;
      for (int l = 0; l < 3; l++) mcnt[l] = 0;
      pipe.delete();
      pipe.push_back(z);
      pipe.push_back(z);
      psince = 0;
   endtask

   // Called on the first tmds_clk of a pixel period, #1 after the edge.
   task automatic run_periods(input int n);
      exp_t        e, o;
      logic [29:0] got;
      logic [9:0]  red, grn, blu;
      bit          in_vs;
      for (int p = 0; p < n; p++) begin
         model_pixel(e);
         pipe.push_back(e);
         mh++;
         if (mh == 800) begin
            mh = 0;
            mv = (mv == 524) ? 0 : mv + 1;
         end
         got = '0;
         for (int k = 0; k < 10; k++) begin
            got[20+k] = lanes.signal_r;
            got[10+k] = lanes.signal_g;
            got[k]    = lanes.signal_b;
            @(posedge tmds_clk);
            #1;
         end
         o = pipe.pop_front();
         check("symbol", {2'b00, got}, {2'b00, o.sym});
         red = got[29:20]; grn = got[19:10]; blu = got[9:0];
         if (psince == 2) check("first_sym", {2'b00, got}, {2'b00, {3{10'h0FF}}});
         if (psince == 3) check("second_sym", {2'b00, got}, {2'b00, {3{10'h200}}});
         if (o.h >= 0) begin
            in_vs = (o.v >= 490 && o.v < 492);
            if (o.h == 0 && o.v < 480)
               check("line_start", {2'b00, got}, {2'b00, {3{10'h0FF}}});
            if (o.h >= 560 && o.h < 640 && o.v < 480)
               check("black_r", {31'd0, (red == 10'h100 || red == 10'h3FF)}, 32'd1);
            if (o.h >= 80 && o.h < 160 && o.v < 480) begin
               check("yellow_g", {31'd0, (grn == 10'h0FF || grn == 10'h200)}, 32'd1);
               check("yellow_b", {31'd0, (blu == 10'h100 || blu == 10'h3FF)}, 32'd1);
            end
            if (o.h >= 640 && o.h < 656 && !in_vs)
               check("blank", {2'b00, got}, {2'b00, 10'h354, 10'h354, 10'h2AB});
            if (o.h >= 656 && o.h < 752 && !in_vs)
               check("hsync_b", {22'd0, blu}, 32'h154);
            if (in_vs && (o.h < 656 || o.h >= 752))
               check("vsync_b", {22'd0, blu}, 32'h0AB);
            if (in_vs && o.h >= 656 && o.h < 752)
               check("hvsync_b", {22'd0, blu}, 32'h354);
         end
         psince++;
      end
   endtask

   task automatic poke(input int h, input int v);
      dut.hcnt = 10'(h);
      dut.vcnt = 10'(v);
      mh = h;
      mv = v;
   endtask

   initial begin
      int ph, pv, k;
      repeat (3) @(posedge tmds_clk);
      #1;
      check("reset_out", {29'd0, lanes.signal_r, lanes.signal_g, lanes.signal_b}, 32'd0);
      check("reset_cnt", {12'd0, dut.bit_cnt, dut.hcnt, dut.vcnt}, 32'd0);
      rst = 1'b0;
      reset_model();

      // line 0 end to end, into the first pixels of line 1
      run_periods(810);

      // random active position, arbitrary disparity history
      ph = $urandom_range(0, 639);
      pv = $urandom_range(1, 478);
      poke(ph, pv);
      run_periods(120 + $urandom_range(0, 40));

      // vertical sync lines 490 and 491
      ph = $urandom_range(560, 700);
      poke(ph, 490);
      run_periods(800 - ph + 800 + 20);

      // frame wrap back to active video
      poke(790, 524);
      run_periods(30);

      // one-clock reset in the middle of a symbol
      run_periods($urandom_range(3, 30));
      k = $urandom_range(1, 8);
      repeat (k) @(posedge tmds_clk);
      #1;
      rst = 1'b1;
      @(posedge tmds_clk);
      #1;
      check("midrst_out", {29'd0, lanes.signal_r, lanes.signal_g, lanes.signal_b}, 32'd0);
      check("midrst_cnt", {12'd0, dut.bit_cnt, dut.hcnt, dut.vcnt}, 32'd0);
      rst = 1'b0;
      reset_model();
      run_periods(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
